// File: rtl/compress_pkg.sv
// compress_pkg: shared types and constants for the RLE compress path.
// Holds FSM state encoding, default run limit and RLE start value.
package compress_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EVAL,
    S_EMIT,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam int MAX_RUN_DEF = 255;

  // Both compress and decompress streams open with a run of zeros.
  localparam logic RLE_START_VAL = 1'b0;

endpackage

// File: rtl/rle_run_counter.sv
// rle_run_counter: tracks current pixel value and run length.
// Ports: clk, rst_n, clr, step, pix -> run_len, emit, emit_val, need_zero.
module rle_run_counter
  import compress_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_RUN = MAX_RUN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              step,
  input  logic              pix,
  output logic [DATA_W-1:0] run_len,
  output logic              emit,
  output logic [DATA_W-1:0] emit_val,
  output logic              need_zero
);

  localparam logic [DATA_W-1:0] MAX_V = DATA_W'(MAX_RUN);

  logic cur_val;
  logic same;
  logic full;

  assign same = (pix == cur_val);
  assign full = (run_len == MAX_V);

  // A full run of the same value is split as MAX_RUN, 0 so the
  // opposite-value run in between stays empty.
  always_comb begin
    emit      = !same || full;
    need_zero = same && full;
    emit_val  = same ? MAX_V : run_len;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cur_val <= RLE_START_VAL;
      run_len <= '0;
    end else if (step) begin
      if (!same)
        cur_val <= ~cur_val;
      run_len <= emit ? DATA_W'(1) : run_len + 1'b1;
    end
  end

endmodule

// File: rtl/compress_handler.sv
// compress_handler: run-length encoder, RAM pixels -> RLE byte stream.
// Ports: clk, RST, start/baseAddr/numPixels, DMA read port
// (ramAddress, ramReadSignal, ramDataOut, ramDoneRead), out stream
// (outData, outValid, outReady), busy, done.
// Macro COMPRESS_STATS_EN adds byteCount (saturating handshake count).
module compress_handler
  import compress_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int MAX_RUN = MAX_RUN_DEF
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [ADDR_W-1:0] numPixels,
  output logic [ADDR_W-1:0] ramAddress,
  output logic              ramReadSignal,
  input  logic [DATA_W-1:0] ramDataOut,
  input  logic              ramDoneRead,
  output logic [DATA_W-1:0] outData,
  output logic              outValid,
  input  logic              outReady,
  output logic              busy,
  output logic              done
`ifdef COMPRESS_STATS_EN
  ,
  output logic [ADDR_W-1:0] byteCount
`endif
);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] rem_next;
  logic              pix;
  logic              pend_zero;
  logic              accept;
  logic              step;
  logic [DATA_W-1:0] run_len;
  logic              emit;
  logic [DATA_W-1:0] emit_val;
  logic              need_zero;

  assign accept   = (state == S_IDLE) && start;
  assign step     = (state == S_EVAL);
  assign rem_next = remaining - 1'b1;

  rle_run_counter #(
    .DATA_W  (DATA_W),
    .MAX_RUN (MAX_RUN)
  ) u_run (
    .clk       (clk),
    .rst_n     (RST),
    .clr       (accept),
    .step      (step),
    .pix       (pix),
    .run_len   (run_len),
    .emit      (emit),
    .emit_val  (emit_val),
    .need_zero (need_zero)
  );

  always_ff @(posedge clk) begin
    if (!RST) begin
      state         <= S_IDLE;
      addr          <= '0;
      remaining     <= '0;
      pix           <= 1'b0;
      pend_zero     <= 1'b0;
      ramAddress    <= '0;
      ramReadSignal <= 1'b0;
      outData       <= '0;
      outValid      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= baseAddr;
            remaining <= numPixels;
            busy      <= 1'b1;
            state     <= (numPixels == '0) ? S_DONE : S_REQ;
          end
        end
        S_REQ: begin
          ramAddress    <= addr;
          ramReadSignal <= 1'b1;
          state         <= S_WAIT;
        end
        S_WAIT: begin
          if (ramDoneRead) begin
            pix           <= |ramDataOut;
            ramReadSignal <= 1'b0;
            state         <= S_EVAL;
          end
        end
        S_EVAL: begin
          remaining <= rem_next;
          addr      <= addr + 1'b1;
          if (emit) begin
            outData   <= emit_val;
            outValid  <= 1'b1;
            pend_zero <= need_zero;
            state     <= S_EMIT;
          end else if (rem_next != '0) begin
            state <= S_REQ;
          end else begin
            state <= S_FLUSH;
          end
        end
        S_EMIT: begin
          if (outReady) begin
            if (pend_zero) begin
              outData   <= '0;
              pend_zero <= 1'b0;
            end else begin
              outValid <= 1'b0;
              state    <= (remaining != '0) ? S_REQ : S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          // First cycle loads the settled run length, then handshake.
          if (!outValid) begin
            outData  <= run_len;
            outValid <= 1'b1;
          end else if (outReady) begin
            outValid <= 1'b0;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef COMPRESS_STATS_EN
  always_ff @(posedge clk) begin
    if (!RST || accept)
      byteCount <= '0;
    else if (outValid && outReady && (byteCount != '1))
      byteCount <= byteCount + 1'b1;
  end
`endif

endmodule

// File: doc/compress_handler.md
Name: compress_handler

Overview:
- Run-length encoder; the inverse of the decompress path.
- Reads a binary image from RAM through the DMA read port, one byte per pixel, where a nonzero byte means pixel=1.
- Emits an RLE byte stream of alternating run lengths, starting with value 0, on a valid/ready output port for the file/IO side.
- Sits beside the decompress handler and shares the DMA read signals through the coordinator mux.

Parameters:
- ADDR_W, 16: RAM address width.
- DATA_W, 8: RAM data width and output byte width.
- MAX_RUN, 255: largest run encodable in one output byte. Must be ≤ 2^DATA_W−1.

Ports:
- clk  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse; accepted only in IDLE.
- baseAddr  input  ADDR_W  first pixel address; latched on start.
- numPixels  input  ADDR_W  pixel count; latched on start.
- ramAddress  output  ADDR_W  DMA read address.
- ramReadSignal  output  1  read request; held until ramDoneRead.
- ramDataOut  input  DATA_W  DMA read data; valid when ramDoneRead=1.
- ramDoneRead  input  1  read-complete pulse.
- outData  output  DATA_W  encoded run length.
- outValid  output  1  outData valid.
- outReady  input  1  consumer accepts when outValid&&outReady.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse at end of stream.

Behaviour:
- Reset (RST=0 at clk edge): state=IDLE, and every output is 0, including ramAddress and outData. Internal curVal=0, runLen=0, remaining=0.
- Reset mid-operation aborts immediately. No partial flush occurs, and an outstanding DMA read is abandoned.
- States: IDLE, REQ, WAIT, EVAL, EMIT, FLUSH, DONE.
- IDLE:
  - start → latch addr=baseAddr, remaining=numPixels, curVal=0, runLen=0; busy=1.
  - If numPixels==0, go to DONE (no bytes emitted). Otherwise go to REQ.
- REQ: drive ramAddress=addr, ramReadSignal=1 → WAIT.
- WAIT: hold ramReadSignal and ramAddress until ramDoneRead; then latch pix=(ramDataOut!=0), drop ramReadSignal → EVAL.
- EVAL, with remaining decremented and addr incremented (wraps at 2^ADDR_W):
  - pix==curVal and runLen<MAX_RUN: runLen++.
  - pix==curVal and runLen==MAX_RUN: queue MAX_RUN then 0, runLen=1, curVal unchanged.
  - pix!=curVal: queue runLen, curVal=~curVal, runLen=1.
  - Next state: EMIT if anything is queued; else REQ if remaining≠0; else FLUSH.
- EMIT:
  - Present queued bytes in order. outValid stays high and outData stays stable until the handshake.
  - One byte per accepted cycle; no further RAM reads while stalled.
  - After the last queued byte: REQ if remaining≠0, else FLUSH.
- FLUSH: emit the final runLen (always ≥1) with the same handshake → DONE.
- DONE: done=1 for one cycle, busy=0 → IDLE.
- A start while busy is ignored.
- The stream sums to numPixels. A leading 0 byte is emitted when the first pixel is 1.
- Latency:
  - Per pixel with no emission: 3 cycles plus DMA wait (REQ, WAIT≥1, EVAL).
  - Each emitted byte: at least 1 cycle.

Optional Feature:
- Macro: COMPRESS_STATS_EN.
- When defined: adds output byteCount[ADDR_W-1:0].
  - Cleared on reset and on start acceptance.
  - Increments on each output handshake and saturates at all-ones.
  - Holds its value after done.
- When undefined: the port and counter are absent, and there is no other behavioural change.

Decomposition:
- Shared package/header compress_pkg holds:
  - state encoding for the seven states;
  - MAX_RUN default;
  - an RLE_START_VAL=0 constant shared with decompress_handler.
- One natural sub-module: rle_run_counter.
  - Holds curVal and runLen.
  - Takes pix/step as inputs.
  - Produces emit, emitVal and needZero (the MAX_RUN overflow case).

Test Plan:
- numPixels=8, pixels 0,0,0,1,1,0,0,0 → bytes 3,2,3; done after last handshake; busy low after.
- numPixels=4, pixels 1,1,1,1 → bytes 0,4.
- numPixels=300 all zero, MAX_RUN=255 → bytes 255,0,45.
- numPixels=0 → no outValid; done pulse within 2 cycles of start.
- Pixels 0,1,0 with outReady=0 for 5 cycles at each byte → outData stable while stalled, ramReadSignal=0 during the stall, bytes 1,1,1; DMA done delayed 4 cycles → same output.
- Assert RST=0 mid-stream after 2 bytes, then restart with numPixels=2, pixels 1,0 → all outputs 0 during reset; new stream 0,1,1. With COMPRESS_STATS_EN, byteCount=3.
